seq_det_param: RTL and testbench
================================

SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_W, default 3, pattern length in bits (2..16).
REQ-002 Parameter PAT_RST, default 3'b101, pattern value loaded at reset.
REQ-003 Parameter CNT_W, default 8, match-counter width.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port arst  input  1  asynchronous, active-low reset.
REQ-006 Port in  input  1  serial data bit.
REQ-007 Port in_valid  input  1  in is sampled only when high.
REQ-008 Port pat_load  input  1  load pat_in as the new pattern.
REQ-009 Port pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
REQ-010 Port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 Port cnt_clr  input  1  synchronous clear of match_cnt and cnt_ovf.
REQ-012 Port out  output  1  registered one-cycle match pulse.
REQ-013 Port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 Port cnt_ovf  output  1  sticky flag, set when a match arrives while match_cnt is at its maximum.

Function
REQ-015 Internal state:
  - pat register, PAT_W bits.
  - hist shift register, PAT_W-1 bits; the newest bit is the LSB.
  - fill counter, 0..PAT_W-1.
REQ-016 FSM state FILL (fill < PAT_W-1): each sampled bit shifts into hist and increments fill; no match is possible.
REQ-017 FSM state ARMED (fill == PAT_W-1): each sampled bit is compared against pat.
  - The compared value is {hist, in}.
  - Match condition: {hist, in} == pat.
REQ-018 On a match, out is high in the cycle after the matching bit's sampling edge (latency 1); otherwise out is 0.
REQ-019 On a match with overlap=1:
  - hist shifts normally.
  - The FSM stays in ARMED, so consecutive matches may share bits (101 on 10101 gives 2 matches).
REQ-020 On a match with overlap=0:
  - hist is cleared.
  - fill is set to 0 and the FSM returns to FILL, so no bit is shared (101 on 10101 gives 1 match).
REQ-021 On a non-match in ARMED: hist shifts and the FSM stays in ARMED.
REQ-022 When in_valid=0: hist, fill and the FSM hold, and out is 0 on the next cycle.
REQ-023 pat_load=1 has priority over in_valid:
  - pat <= pat_in.
  - hist and fill are cleared and the FSM enters FILL.
  - No match is evaluated in that cycle.
REQ-024 overlap is sampled per cycle; changing it mid-stream affects only the next match decision.
REQ-025 On each match, match_cnt increments by 1 and saturates at 2^CNT_W-1.
  - A match while saturated sets cnt_ovf.
  - cnt_ovf stays set until cnt_clr or reset.
REQ-026 cnt_clr has priority over an increment in the same cycle: match_cnt=0 and cnt_ovf=0; out still pulses.
REQ-027 With PAT_W=2 the FILL state spans exactly one sampled bit.

Reset
REQ-028 When arst is low, the following take effect immediately, independent of clk:
  - out=0, match_cnt=0, cnt_ovf=0.
  - hist=0, fill=0, FSM=FILL.
  - pat=PAT_RST.
REQ-029 Reset asserted mid-pattern discards partial history; detection restarts from FILL after release.
REQ-030 Release is synchronised by the system; no sampling occurs on the edge where arst is low.

Structure
REQ-031 Package seq_det_pkg holds the FSM state encoding (FILL, ARMED) and the CNT_W/PAT_W defaults.
REQ-032 The saturating counter with sticky overflow is sub-module sat_match_cnt (ports: clk, arst, inc, clr, cnt, ovf).
REQ-033 The shift, compare and FSM logic lives in seq_det_param; the expected implementation is 150-250 lines.

Verification
REQ-034 Reset defaults (PAT_W=3), in_valid=1, stream 1,0,1,0,1 with overlap=1: out pulses 1 cycle after the 3rd and 5th bits; match_cnt=2.
REQ-035 Same stream with overlap=0: a single out pulse after the 3rd bit; match_cnt=1.
REQ-036 Load pat_in=3'b110 mid-stream after bits 1,1, then send 1,1,0: no match from the pre-load bits; match after the post-load 0; match_cnt increments by 1.
REQ-037 CNT_W=2, six matches: match_cnt reads 1,2,3,3,3,3; cnt_ovf rises on the 4th match; cnt_clr coincident with a match gives match_cnt=0, cnt_ovf=0, out=1.
REQ-038 Bits 1,0 then in_valid=0 for 5 cycles, then 1: a match follows the final 1 with latency 1, and out stays 0 during the gap.
REQ-039 arst pulled low after bits 1,0, released, then 1: no match; the subsequent 0,1 produces a match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parameterised serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        StFill,
        StArmed
    } seq_state_e;

    localparam int unsigned PAT_W_DEF   = 3;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam logic [2:0]  PAT_RST_DEF = 3'b101;

endpackage

// File: rtl/sat_match_cnt.sv
// Saturating match counter with a sticky overflow flag; clear wins over increment.
module sat_match_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;

    always_comb begin
        cnt_d = cnt;
        ovf_d = ovf;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt == {CNT_W{1'b1}}) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_d;
            ovf <= ovf_d;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Serial pattern detector with loadable pattern, selectable overlap and a
// saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
    parameter int unsigned      CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_ovf
);

    localparam int unsigned FW = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] window;
    logic             match;

    // Newest bit enters at the LSB, so the window reads oldest-first like pat.
    assign window = {hist_q, in};

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match   = 1'b0;
        if (pat_load) begin
            pat_d   = pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = StFill;
        end else if (in_valid) begin
            unique case (state_q)
                StFill: begin
                    hist_d = window[PAT_W-2:0];
                    fill_d = fill_q + FW'(1);
                    if (fill_q == FW'(PAT_W - 2)) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    match = (window == pat_q);
                    if (match && !overlap) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        state_d = StFill;
                    end else begin
                        hist_d = window[PAT_W-2:0];
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= StFill;
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            out     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out     <= match;
        end
    end

    sat_match_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk (clk),
        .arst(arst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt),
        .ovf (cnt_ovf)
    );

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios plus random traffic against a queue-based model.
module tb_seq_det_param;

    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          din = 1'b0;
    logic          in_valid = 1'b0;
    logic          pat_load = 1'b0;
    logic [PW-1:0] pat_in = '0;
    logic          overlap = 1'b1;
    logic          cnt_clr = 1'b0;
    logic          out8, out2, ovf8, ovf2;
    logic [7:0]    cnt8;
    logic [1:0]    cnt2;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    bit          hq[$];
    logic [PW-1:0] m_pat;
    int          m_cnt8, m_cnt2;
    bit          m_ovf8, m_ovf2, m_out;

    always #5 clk = ~clk;

    seq_det_param dut8 (
        .clk(clk), .arst(arst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr), .out(out8),
        .match_cnt(cnt8), .cnt_ovf(ovf8)
    );

    seq_det_param #(.PAT_W(3), .PAT_RST(3'b101), .CNT_W(2)) dut2 (
        .clk(clk), .arst(arst), .in(din), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .cnt_clr(cnt_clr), .out(out2),
        .match_cnt(cnt2), .cnt_ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_pat  = 3'b101;
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_ovf8 = 0;
        m_ovf2 = 0;
        m_out  = 0;
    endtask

    task automatic bump(inout int c, inout bit o, input int maxv);
        if (c == maxv) o = 1;
        else c++;
    endtask

    // A match is "the last PW sampled bits since the last restart equal the pattern".
    task automatic model_edge();
        bit m;
        logic [PW-1:0] v;
        m = 0;
        if (pat_load) begin
            m_pat = pat_in;
            hq.delete();
        end else if (in_valid) begin
            hq.push_back(din);
            if (hq.size() >= PW) begin
                for (int i = 0; i < PW; i++) v[PW-1-i] = hq[hq.size() - PW + i];
                if (v == m_pat) begin
                    m = 1;
                    if (!overlap) hq.delete();
                end
            end
            while (hq.size() > PW - 1) void'(hq.pop_front());
        end
        m_out = m;
        if (cnt_clr) begin
            m_cnt8 = 0; m_ovf8 = 0; m_cnt2 = 0; m_ovf2 = 0;
        end else if (m) begin
            bump(m_cnt8, m_ovf8, 255);
            bump(m_cnt2, m_ovf2, 3);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out8"}, 32'(out8), 32'(m_out));
        chk({tag, ".out2"}, 32'(out2), 32'(m_out));
        chk({tag, ".cnt8"}, 32'(cnt8), 32'(m_cnt8));
        chk({tag, ".ovf8"}, 32'(ovf8), 32'(m_ovf8));
        chk({tag, ".cnt2"}, 32'(cnt2), 32'(m_cnt2));
        chk({tag, ".ovf2"}, 32'(ovf2), 32'(m_ovf2));
    endtask

    task automatic step(input string tag, input bit v, input bit b, input bit ld,
                        input logic [PW-1:0] pin, input bit ov, input bit clr);
        in_valid = v; din = b; pat_load = ld; pat_in = pin; overlap = ov; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic send(input string tag, input bit b, input bit ov);
        step(tag, 1'b1, b, 1'b0, '0, ov, 1'b0);
    endtask

    // Assert reset between edges, check outputs clear at once, release at a falling edge.
    task automatic do_reset(input string tag);
        #1 arst = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        arst = 1'b1;

        // Overlapping detection of 101 in 10101
        send("ov.b1", 1, 1); send("ov.b2", 0, 1); send("ov.b3", 1, 1);
        chk("ov.pulse3", 32'(out8), 32'd1);
        send("ov.b4", 0, 1); send("ov.b5", 1, 1);
        chk("ov.pulse5", 32'(out8), 32'd1);
        chk("ov.cnt", 32'(cnt8), 32'd2);

        // Non-overlapping: reload pattern to restart history, clear count
        step("nov.load", 1, 0, 1, 3'b101, 0, 1);
        send("nov.b1", 1, 0); send("nov.b2", 0, 0); send("nov.b3", 1, 0);
        send("nov.b4", 0, 0); send("nov.b5", 1, 0);
        chk("nov.cnt", 32'(cnt8), 32'd1);

        // Mid-stream load of 110
        step("ld.clr", 0, 0, 0, '0, 1, 1);
        send("ld.b1", 1, 1); send("ld.b2", 1, 1);
        step("ld.load", 1, 1, 1, 3'b110, 1, 0);
        send("ld.c1", 1, 1); send("ld.c2", 1, 1); send("ld.c3", 0, 1);
        chk("ld.pulse", 32'(out8), 32'd1);
        chk("ld.cnt", 32'(cnt8), 32'd1);

        // Saturation on the CNT_W=2 instance
        step("sat.load", 1, 0, 1, 3'b111, 1, 1);
        for (int i = 0; i < 8; i++) send("sat.bit", 1, 1);
        chk("sat.cnt2", 32'(cnt2), 32'd3);
        chk("sat.ovf2", 32'(ovf2), 32'd1);
        step("sat.clr", 1, 1, 0, '0, 1, 1);
        chk("sat.clr_out", 32'(out2), 32'd1);
        chk("sat.clr_cnt", 32'(cnt2), 32'd0);

        // in_valid gap
        step("gap.load", 1, 0, 1, 3'b101, 1, 1);
        send("gap.b1", 1, 1); send("gap.b2", 0, 1);
        for (int i = 0; i < 5; i++) step("gap.idle", 0, 1, 0, '0, 1, 0);
        send("gap.b3", 1, 1);
        chk("gap.pulse", 32'(out8), 32'd1);

        // Reset mid-pattern discards history
        send("rst.b1", 1, 1); send("rst.b2", 0, 1);
        do_reset("rst.mid");
        send("rst.c1", 1, 1);
        chk("rst.nomatch", 32'(out8), 32'd0);
        send("rst.c2", 0, 1); send("rst.c3", 1, 1);
        chk("rst.match", 32'(out8), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset("rnd.rst");
            step("rnd", ($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 19) == 0),
                 3'($urandom), 1'($urandom), ($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
